msxbus_sched: RTL and testbench

MSXBUS_SCHED -- requirements
Module: msxbus_sched

---
 rtl/msxbus_sched.sv | 202 ++++++++++++++++++++
 tb/tb_msxbus_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msxbus_sched.sv
// MSX bus cycle scheduler: two requesters share one MSX slot bus (address, strobe, hold, recovery).
// Optional round-robin arbitration with `define MSXBUS_SCHED_RR_EN; otherwise req0 has fixed priority.
module msxbus_sched #(
  parameter int unsigned T_ADDR  = 2,
  parameter int unsigned T_STRB  = 4,
  parameter int unsigned T_IOX   = 2,
  parameter int unsigned WAIT_TO = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        rw0,
  input  logic        rw1,
  input  logic        meio0,
  input  logic        meio1,
  input  logic        slt0,
  input  logic        slt1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err,
  output logic [7:0]  rdata,
  output logic [15:0] maddr,
  output logic [7:0]  mdata_o,
  output logic        mdata_oe,
  input  logic [7:0]  mdata_i,
  output logic        mrd,
  output logic        mwr,
  output logic        mmreq,
  output logic        miorq,
  output logic        msltsl1,
  output logic        msltsl2,
  input  logic        mwait,
  output logic        busy
);

  localparam int unsigned SMIN_IO = T_STRB + T_IOX;
  localparam int unsigned CMAX    = (SMIN_IO > T_ADDR) ? SMIN_IO : T_ADDR;
  localparam int unsigned CW      = $clog2(CMAX + 1);
  localparam int unsigned WW      = $clog2(WAIT_TO + 1);

  typedef enum logic [2:0] {IDLE, ADDR, STRB, HOLD, RECOV} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, smin_m1;
  logic [WW-1:0] wcnt, wcnt_nxt;
  logic          abort_q, abort_nxt;
  logic          gnt_q, gnt_nxt;
  logic          rw_q, rw_nxt, meio_q, meio_nxt, slt_q, slt_nxt;
  logic [15:0]   addr_nxt;
  logic [7:0]    wdata_nxt, rdata_nxt;
  logic          mw_s1, mw_s2;
  logic          take1, active;

`ifdef MSXBUS_SCHED_RR_EN
  logic ptr, ptr_nxt;
  // ptr names the requester favoured on a tie; it flips to the other side on every grant
  assign take1 = req1 & (~req0 | ptr);
`else
  assign take1 = req1 & ~req0;
`endif

  assign smin_m1 = meio_q ? CW'(T_STRB - 1) : CW'(SMIN_IO - 1);
  assign active  = (state_nxt == ADDR) || (state_nxt == STRB);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mw_s1 <= 1'b1;
      mw_s2 <= 1'b1;
    end else begin
      mw_s1 <= mwait;
      mw_s2 <= mw_s1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      wcnt    <= '0;
      abort_q <= 1'b0;
      gnt_q   <= 1'b0;
      rw_q    <= 1'b0;
      meio_q  <= 1'b0;
      slt_q   <= 1'b0;
`ifdef MSXBUS_SCHED_RR_EN
      ptr     <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      wcnt    <= wcnt_nxt;
      abort_q <= abort_nxt;
      gnt_q   <= gnt_nxt;
      rw_q    <= rw_nxt;
      meio_q  <= meio_nxt;
      slt_q   <= slt_nxt;
`ifdef MSXBUS_SCHED_RR_EN
      ptr     <= ptr_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wcnt_nxt  = wcnt;
    abort_nxt = abort_q;
    gnt_nxt   = gnt_q;
    rw_nxt    = rw_q;
    meio_nxt  = meio_q;
    slt_nxt   = slt_q;
    addr_nxt  = maddr;
    wdata_nxt = mdata_o;
    rdata_nxt = rdata;
`ifdef MSXBUS_SCHED_RR_EN
    ptr_nxt   = ptr;
`endif
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt = ADDR;
          cnt_nxt   = '0;
          wcnt_nxt  = '0;
          abort_nxt = 1'b0;
          gnt_nxt   = take1;
          rw_nxt    = take1 ? rw1    : rw0;
          meio_nxt  = take1 ? meio1  : meio0;
          slt_nxt   = take1 ? slt1   : slt0;
          addr_nxt  = take1 ? addr1  : addr0;
          wdata_nxt = take1 ? wdata1 : wdata0;
`ifdef MSXBUS_SCHED_RR_EN
          ptr_nxt   = ~take1;
`endif
        end
      end
      ADDR: begin
        if (cnt == CW'(T_ADDR - 1)) begin
          state_nxt = STRB;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STRB: begin
        // cnt stops at the minimum; wcnt then counts extension cycles until mwait or timeout
        if (cnt < smin_m1) begin
          cnt_nxt = cnt + CW'(1);
        end else if (mw_s2 || (wcnt == WW'(WAIT_TO))) begin
          state_nxt = HOLD;
          abort_nxt = ~mw_s2;
          if (!rw_q) rdata_nxt = mdata_i;
        end else begin
          wcnt_nxt = wcnt + WW'(1);
        end
      end
      HOLD:    state_nxt = RECOV;
      RECOV:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // All bus outputs are registered from the next-state decode so strobes never glitch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      maddr    <= '0;
      mdata_o  <= '0;
      rdata    <= '0;
      mdata_oe <= 1'b0;
      mrd      <= 1'b1;
      mwr      <= 1'b1;
      mmreq    <= 1'b1;
      miorq    <= 1'b1;
      msltsl1  <= 1'b1;
      msltsl2  <= 1'b1;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      maddr    <= addr_nxt;
      mdata_o  <= wdata_nxt;
      rdata    <= rdata_nxt;
      mdata_oe <= rw_nxt && (active || state_nxt == HOLD);
      mrd      <= ~((state_nxt == STRB) && !rw_nxt);
      mwr      <= ~((state_nxt == STRB) && rw_nxt);
      mmreq    <= ~(active && meio_nxt);
      miorq    <= ~(active && !meio_nxt);
      msltsl1  <= ~(active && meio_nxt && slt_nxt);
      msltsl2  <= ~(active && meio_nxt && !slt_nxt);
      ack0     <= (state_nxt == HOLD) && !gnt_nxt;
      ack1     <= (state_nxt == HOLD) && gnt_nxt;
      err      <= (state_nxt == HOLD) && abort_nxt;
      busy     <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_msxbus_sched.sv
// Bench for msxbus_sched: vector table, randomized transactions against a cycle-phase reference
// model, and hand sequences for arbitration and asynchronous reset.
module tb_msxbus_sched;

  localparam int TA  = 2;
  localparam int TS  = 4;
  localparam int TX  = 2;
  localparam int WTO = 255;

  logic        clk, reset;
  logic        req0, req1, rw0, rw1, meio0, meio1, slt0, slt1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1, err;
  logic [7:0]  rdata;
  logic [15:0] maddr;
  logic [7:0]  mdata_o, mdata_i;
  logic        mdata_oe, mrd, mwr, mmreq, miorq, msltsl1, msltsl2, mwait, busy;

  msxbus_sched #(.T_ADDR(TA), .T_STRB(TS), .T_IOX(TX), .WAIT_TO(WTO)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .meio0(meio0), .meio1(meio1), .slt0(slt0), .slt1(slt1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata),
    .maddr(maddr), .mdata_o(mdata_o), .mdata_oe(mdata_oe), .mdata_i(mdata_i),
    .mrd(mrd), .mwr(mwr), .mmreq(mmreq), .miorq(miorq),
    .msltsl1(msltsl1), .msltsl2(msltsl2), .mwait(mwait), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic ack0, ack1, err, busy, mrd, mwr, mmreq, miorq, s1, s2, oe;
    logic [7:0]  rdata;
    logic [15:0] maddr;
    logic [7:0]  mdo;
  } outs_t;

  typedef struct {
    bit          who, rw, meio, slt;
    logic [15:0] addr;
    logic [7:0]  wdata, rdv;
    int          dstep, nlow;
    int          e_ackk, e_len;
    logic [7:0]  e_rdata;
    bit          e_err;
  } vec_t;

  int         nchecks, nerr, txn_id;
  logic [7:0] rdata_m;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic outs_t grab();
    outs_t o;
    o = '{ack0:ack0, ack1:ack1, err:err, busy:busy, mrd:mrd, mwr:mwr, mmreq:mmreq, miorq:miorq,
          s1:msltsl1, s2:msltsl2, oe:mdata_oe, rdata:rdata, maddr:maddr, mdo:mdata_o};
    return o;
  endfunction

  function automatic outs_t idle_vec(input logic [7:0] rd);
    outs_t e;
    e = '0;
    e.mrd = 1'b1; e.mwr = 1'b1; e.mmreq = 1'b1; e.miorq = 1'b1; e.s1 = 1'b1; e.s2 = 1'b1;
    e.rdata = rd;
    return e;
  endfunction

  // Strobe length: min cycles, extended until synchronized (2-cycle delayed) mwait is high, capped by timeout
  function automatic void model_len(input vec_t v, output int len, output bit ab);
    int minc, jn, jab;
    minc = v.meio ? TS : TS + TX;
    jn   = (v.nlow + 2 > minc - 1) ? v.nlow + 2 : minc - 1;
    jab  = minc - 1 + WTO;
    if (jn <= jab) begin len = jn + 1; ab = 1'b0; end
    else           begin len = jab + 1; ab = 1'b1; end
  endfunction

  function automatic outs_t expect_at(input int k, input vec_t v, input int len, input bit ab,
                                      input logic [7:0] rd_old, input logic [7:0] rd_new);
    outs_t e;
    e = idle_vec((k >= TA + len) ? rd_new : rd_old);
    e.maddr = v.addr;
    e.mdo   = v.wdata;
    if (k <= TA + len + 1) e.busy = 1'b1;
    if (k < TA + len) begin
      e.mmreq = ~v.meio;
      e.miorq = v.meio;
      e.s1    = ~(v.meio & v.slt);
      e.s2    = ~(v.meio & ~v.slt);
      e.oe    = v.rw;
      if (k >= TA) begin
        e.mrd = v.rw;
        e.mwr = ~v.rw;
      end
    end else if (k == TA + len) begin
      e.oe   = v.rw;
      e.ack0 = ~v.who;
      e.ack1 = v.who;
      e.err  = ab;
    end
    return e;
  endfunction

  task automatic scramble();
    rw0 = 1'($urandom); rw1 = 1'($urandom); meio0 = 1'($urandom); meio1 = 1'($urandom);
    slt0 = 1'($urandom); slt1 = 1'($urandom);
    addr0 = 16'($urandom); addr1 = 16'($urandom); wdata0 = 8'($urandom); wdata1 = 8'($urandom);
  endtask

  // Called with the DUT idle; the request is granted on the next rising edge (k = 0 after it)
  task automatic run_txn(input vec_t v, output int ackk, output int slen,
                         output logic [7:0] rd, output bit er);
    int len, endk;
    bit ab;
    logic [7:0] rd_new;
    outs_t a, e;
    model_len(v, len, ab);
    endk   = TA + len + 2;
    rd_new = v.rw ? rdata_m : v.rdv + 8'(v.dstep * (TA + len - 1));
    if (v.who) begin
      req1 = 1'b1; rw1 = v.rw; meio1 = v.meio; slt1 = v.slt; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; rw0 = v.rw; meio0 = v.meio; slt0 = v.slt; addr0 = v.addr; wdata0 = v.wdata;
    end
    mwait = 1'b1;
    ackk = -1; slen = 0; rd = '0; er = 1'b0;
    for (int k = 0; k <= endk; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        req0 = 1'b0; req1 = 1'b0;
        scramble();
      end
      mwait   = (k >= TA && k - TA < v.nlow) ? 1'b0 : 1'b1;
      mdata_i = v.rdv + 8'(v.dstep * k);
      @(negedge clk);
      a = grab();
      e = expect_at(k, v, len, ab, rdata_m, rd_new);
      if (!e.oe)   begin a.mdo = '0;   e.mdo = '0;   end
      if (!e.busy) begin a.maddr = '0; e.maddr = '0; end
      chk($sformatf("txn%0d k%0d outputs", txn_id, k), 64'(a), 64'(e));
      if ((a.ack0 || a.ack1) && ackk < 0) begin
        ackk = k; er = a.err; rd = a.rdata;
      end
      if (!a.mrd || !a.mwr) slen++;
    end
    rdata_m = rd_new;
    mwait   = 1'b1;
    txn_id++;
  endtask

  task automatic do_reset();
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; mwait = 1'b1;
    #2;
    chk("reset state", 64'(grab()), 64'(idle_vec(8'h00)));
    @(posedge clk);
    @(negedge clk);
    chk("reset held", 64'(grab()), 64'(idle_vec(8'h00)));
    reset   = 1'b1;
    rdata_m = '0;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  vec_t tab[6];
  vec_t rv;
  int   ackk, slen, n;
  int   ord[4];
  bit   er;
  logic [7:0] rd;

  initial begin
    nchecks = 0; nerr = 0; txn_id = 0; rdata_m = '0;
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; mwait = 1'b1; mdata_i = '0;
    rw0 = 0; rw1 = 0; meio0 = 0; meio1 = 0; slt0 = 0; slt1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    //           who rw meio slt addr      wdata  rdv    step nlow  ackk len  rdata  err
    tab[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h4000, 8'h00, 8'hA5, 0, 0,    6,   4,   8'hA5, 1'b0};
    tab[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0098, 8'h3C, 8'h00, 0, 0,    8,   6,   8'hA5, 1'b0};
    tab[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h8123, 8'h00, 8'h5A, 0, 10,   15,  13,  8'h5A, 1'b0};
    tab[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'hC000, 8'h00, 8'h77, 0, 1000, 261, 259, 8'h77, 1'b1};
    tab[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 8'hC3, 8'h00, 0, 3,    8,   6,   8'h77, 1'b0};
    tab[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h00A8, 8'h00, 8'h19, 0, 5,    10,  8,   8'h19, 1'b0};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 6; i++) begin
      run_txn(tab[i], ackk, slen, rd, er);
      chk($sformatf("vec%0d ack cycle", i), 64'(ackk), 64'(tab[i].e_ackk));
      chk($sformatf("vec%0d strobe len", i), 64'(slen), 64'(tab[i].e_len));
      chk($sformatf("vec%0d rdata", i), 64'(rd), 64'(tab[i].e_rdata));
      chk($sformatf("vec%0d err", i), 64'(er), 64'(tab[i].e_err));
    end

    // A request withdrawn before the next edge is never granted
    req1 = 1'b1;
    #2 req1 = 1'b0;
    @(negedge clk);
    chk("dropped req ignored", 64'(busy), 64'(0));

    for (int i = 0; i < 30; i++) begin
      rv.who   = 1'($urandom);  rv.rw   = 1'($urandom);
      rv.meio  = 1'($urandom);  rv.slt  = 1'($urandom);
      rv.addr  = 16'($urandom); rv.wdata = 8'($urandom); rv.rdv = 8'($urandom);
      rv.dstep = int'($urandom_range(1, 5));
      rv.nlow  = ($urandom_range(0, 9) == 0) ? 400 : int'($urandom_range(0, 12));
      run_txn(rv, ackk, slen, rd, er);
    end

    // Asynchronous reset in the middle of a strobe: everything released at once, no ack
    req0 = 1'b1; rw0 = 1'b1; meio0 = 1'b1; slt0 = 1'b1; addr0 = 16'hBEEF; wdata0 = 8'h11;
    @(posedge clk); #1;
    req0 = 1'b0;
    repeat (TA + 1) @(posedge clk);
    #3 reset = 1'b0;
    #1 chk("async reset mid-strobe", 64'(grab()), 64'(idle_vec(8'h00)));
    @(posedge clk);
    @(negedge clk);
    chk("reset across edge no ack", 64'(grab()), 64'(idle_vec(8'h00)));
    reset   = 1'b1;
    rdata_m = '0;
    rv = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h7F00, 8'h00, 8'h42, 0, 0, 6, 4, 8'h42, 1'b0};
    run_txn(rv, ackk, slen, rd, er);
    chk("post-reset ack cycle", 64'(ackk), 64'(6));
    chk("post-reset rdata", 64'(rd), 64'(8'h42));

    // Both requesters held: grant order from reset
    do_reset();
    rw0 = 0; rw1 = 0; meio0 = 1; meio1 = 1; slt0 = 1; slt1 = 0;
    addr0 = 16'h1111; addr1 = 16'h2222; mdata_i = 8'h6E; mwait = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (ack0)      begin ord[n] = 0; n++; end
      else if (ack1) begin ord[n] = 1; n++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("grant count", 64'(n), 64'(4));
    for (int i = 0; i < n; i++) begin
`ifdef MSXBUS_SCHED_RR_EN
      chk($sformatf("grant order %0d", i), 64'(ord[i]), 64'(i % 2));
`else
      chk($sformatf("grant order %0d", i), 64'(ord[i]), 64'(0));
`endif
    end
    repeat (3) @(negedge clk);
    chk("idle after grants", 64'(busy), 64'(0));
    chk("rdata after grants", 64'(rdata), 64'(8'h6E));

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
